// File: rtl/symbol_feeder.sv
// symbol_feeder: serializes 8-bit words into four 2-bit symbols, MSB pair first.
// A one-word holding buffer lets the next word be loaded while the current
// word shifts out, so a steady source gives back-to-back words with no gap.
//
// Ports:
//   clock      rising-edge system clock
//   clear_n    asynchronous active-low reset
//   din        word to serialize
//   load       write strobe for din (accepted only when ready=1)
//   hold       stall request from the downstream stage
//   ready      holding buffer empty
//   x1, x0     current symbol (MSB, LSB)
//   sym_valid  x1/x0 carry a live symbol
//   last       current symbol is the 4th of its word
//   word_cnt   count of fully emitted words (mod 256)
//   ovf        sticky: a load arrived while the buffer was full
//
// All outputs are decoded from registers only; no input reaches an output
// combinationally.
module symbol_feeder (
    input  logic       clock,
    input  logic       clear_n,
    input  logic [7:0] din,
    input  logic       load,
    input  logic       hold,
    output logic       ready,
    output logic       x1,
    output logic       x0,
    output logic       sym_valid,
    output logic       last,
    output logic [7:0] word_cnt,
    output logic       ovf
);

    localparam int unsigned W_DATA = 8;
    localparam int unsigned W_IDX  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [W_DATA-1:0]   hbuf_q, hbuf_d;
    logic                hfull_q, hfull_d;
    logic [W_DATA-1:0]   sreg_q, sreg_d;
    logic [W_IDX-1:0]    idx_q, idx_d;
    logic [W_DATA-1:0]   word_cnt_q, word_cnt_d;
    logic                ovf_q, ovf_d;
    logic [1:0]          sym_c;

    // State register
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= IDLE;
            hbuf_q     <= '0;
            hfull_q    <= 1'b0;
            sreg_q     <= '0;
            idx_q      <= '0;
            word_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hbuf_q     <= hbuf_d;
            hfull_q    <= hfull_d;
            sreg_q     <= sreg_d;
            idx_q      <= idx_d;
            word_cnt_q <= word_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        hbuf_d     = hbuf_q;
        hfull_d    = hfull_q;
        sreg_d     = sreg_q;
        idx_d      = idx_q;
        word_cnt_d = word_cnt_q;
        ovf_d      = ovf_q;

        // Drain side: move hbuf into the shifter when allowed
        case (state_q)
            IDLE: begin
                if (hfull_q && !hold) begin
                    sreg_d  = hbuf_q;
                    hfull_d = 1'b0;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!hold) begin
                    if (idx_q != W_IDX'(3)) begin
                        idx_d = W_IDX'(idx_q + W_IDX'(1));
                    end else begin
                        word_cnt_d = W_DATA'(word_cnt_q + W_DATA'(1));
                        if (hfull_q) begin
                            sreg_d  = hbuf_q;
                            hfull_d = 1'b0;
                            idx_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Fill side: judged on the pre-edge full flag, so a load coincident
        // with a drain of a full buffer is still dropped.
        if (load) begin
            if (!hfull_q) begin
                hbuf_d  = din;
                hfull_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // Symbol decode from the shifter, MSB pair first
    always_comb begin
        sym_c = 2'b00;
        if (state_q == SHIFT) begin
            case (idx_q)
                2'd0:    sym_c = sreg_q[7:6];
                2'd1:    sym_c = sreg_q[5:4];
                2'd2:    sym_c = sreg_q[3:2];
                default: sym_c = sreg_q[1:0];
            endcase
        end
    end

    assign ready     = ~hfull_q;
    assign x1        = sym_c[1];
    assign x0        = sym_c[0];
    assign sym_valid = (state_q == SHIFT);
    assign last      = (state_q == SHIFT) && (idx_q == W_IDX'(3));
    assign word_cnt  = word_cnt_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_symbol_feeder.sv
// Scoreboard bench for symbol_feeder: stimulus pushes expected symbols per
// accepted word; a negedge monitor pops and compares each consumed symbol.
module tb_symbol_feeder;

    logic       clock;
    logic       clear_n;
    logic [7:0] din;
    logic       load;
    logic       hold;
    logic       ready;
    logic       x1;
    logic       x0;
    logic       sym_valid;
    logic       last;
    logic [7:0] word_cnt;
    logic       ovf;

    int checks = 0;
    int errors = 0;
    int run_len = 0;
    int max_run = 0;
    logic [2:0] exp_q[$];   // {x1, x0, last}

    symbol_feeder dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .din       (din),
        .load      (load),
        .hold      (hold),
        .ready     (ready),
        .x1        (x1),
        .x0        (x0),
        .sym_valid (sym_valid),
        .last      (last),
        .word_cnt  (word_cnt),
        .ovf       (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected symbols of one word, MSB pair first
    task automatic push_word(input logic [7:0] w);
        exp_q.push_back({w[7:6], 1'b0});
        exp_q.push_back({w[5:4], 1'b0});
        exp_q.push_back({w[3:2], 1'b0});
        exp_q.push_back({w[1:0], 1'b1});
    endtask

    // Wait for ready, strobe load for one cycle, record the word as expected
    task automatic load_word(input logic [7:0] w);
        int n = 0;
        @(posedge clock); #1;
        while (!ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (!ready) begin
            checks++; errors++;
            $display("FAIL load_wait_ready: ready stuck at 0 expected 1");
        end
        din  = w;
        load = 1'b1;
        @(posedge clock); #1;
        load = 1'b0;
        push_word(w);
    endtask

    // Wait until all expected symbols are consumed and the block is idle
    task automatic wait_idle();
        int n = 0;
        @(negedge clock); #1;
        while (!(exp_q.size() == 0 && !sym_valid && ready) && n < 500) begin
            @(negedge clock); #1;
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL wait_idle: timeout with %0d symbols pending expected 0", exp_q.size());
        end
    endtask

    // Monitor: a symbol is consumed on each valid, non-held cycle
    always @(negedge clock) begin
        if (sym_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (sym_valid && !hold) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL symbol_unexpected: got %b%b last=%b expected none", x1, x0, last);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                chk("symbol", {29'd0, x1, x0, last}, {29'd0, e});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_n = 1'b0;
        din     = 8'h00;
        load    = 1'b0;
        hold    = 1'b0;

        // Reset state (no clock edge needed)
        #3;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_sym_valid", 32'(sym_valid), 32'd0);
        chk("rst_sym", {30'd0, x1, x0}, 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        #19 clear_n = 1'b1;

        // Single word 01_10_11_00 with one-cycle load-to-symbol latency
        load_word(8'b01_10_11_00);
        chk("lat_valid_n0", 32'(sym_valid), 32'd0);
        chk("lat_ready_n0", 32'(ready), 32'd0);
        @(posedge clock); #1;
        chk("lat_valid_n1", 32'(sym_valid), 32'd1);
        chk("lat_sym_n1", {30'd0, x1, x0}, 32'd1);
        wait_idle();
        chk("single_word_cnt", 32'(word_cnt), 32'd1);
        chk("single_idle_last", 32'(last), 32'd0);

        // Back-to-back E4 then 1B: 8 contiguous symbols
        max_run = 0;
        load_word(8'hE4);
        load_word(8'h1B);
        wait_idle();
        chk("b2b_contig_run", 32'(max_run), 32'd8);
        chk("b2b_word_cnt", 32'(word_cnt), 32'd3);
        chk("b2b_ovf", 32'(ovf), 32'd0);

        // Overflow: buffer full, FF dropped, ovf sticky
        load_word(8'hA5);
        load_word(8'h3C);
        chk("ovf_ready_full", 32'(ready), 32'd0);
        din  = 8'hFF;
        load = 1'b1;
        @(posedge clock); #1;
        load = 1'b0;
        chk("ovf_set", 32'(ovf), 32'd1);
        wait_idle();
        chk("ovf_sticky", 32'(ovf), 32'd1);
        chk("ovf_word_cnt", 32'(word_cnt), 32'd5);

        // Stall 3 cycles at idx=1 of word 10_01_00_11
        load_word(8'h93);
        begin
            int n = 0;
            @(negedge clock);
            while (!sym_valid && n < 20) begin
                @(negedge clock);
                n++;
            end
            chk("stall_first_valid", 32'(sym_valid), 32'd1);
        end
        @(posedge clock); #1;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_frozen_sym", {30'd0, x1, x0}, 32'd1);
            chk("stall_frozen_valid", 32'(sym_valid), 32'd1);
            chk("stall_frozen_last", 32'(last), 32'd0);
            @(posedge clock); #1;
        end
        hold = 1'b0;
        wait_idle();
        chk("stall_word_cnt", 32'(word_cnt), 32'd6);

        // Wrap: 249 more words to 255, then one more to 0
        for (int k = 0; k < 249; k++) load_word(8'(k * 37 + 11));
        wait_idle();
        chk("wrap_255", 32'(word_cnt), 32'd255);
        load_word(8'h5A);
        wait_idle();
        chk("wrap_0", 32'(word_cnt), 32'd0);
        chk("wrap_ovf_sticky", 32'(ovf), 32'd1);

        // Asynchronous reset mid-word
        load_word(8'hC3);
        load_word(8'h7E);
        @(posedge clock); #3;
        clear_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_ready", 32'(ready), 32'd1);
        chk("arst_sym_valid", 32'(sym_valid), 32'd0);
        chk("arst_sym", {30'd0, x1, x0}, 32'd0);
        chk("arst_last", 32'(last), 32'd0);
        chk("arst_word_cnt", 32'(word_cnt), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        #17 clear_n = 1'b1;

        // Operation resumes cleanly after reset
        load_word(8'hC6);
        wait_idle();
        chk("resume_word_cnt", 32'(word_cnt), 32'd1);
        chk("resume_ovf", 32'(ovf), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
